// File: rtl/sync_fifo_prefill_mc.sv
// Multi-channel synchronous FIFO with show-ahead output and a pre-fill gate.
// NUM_CH lanes share one pointer set; reads are held off until the threshold is reached.
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | collecting data; m_valid forced low when GATE_EN=1
// RUN   | gate open; m_valid = !empty until the FIFO drains to zero
module sync_fifo_prefill_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter bit GATE_EN    = 1'b1,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    localparam int W  = NUM_CH * DATA_WIDTH,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          drain,
    input  logic [AW:0]   prefill_level,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [W-1:0]  s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          pre_fill_done
);

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count_next;
    logic [AW:0]  thr;
    logic         push;
    logic         pop;
    state_t       state;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign s_ready      = !full;
    assign m_valid      = (GATE_EN && state != RUN) ? 1'b0 : !empty;
    assign m_data       = mem[rd_ptr[AW-1:0]];
    assign push         = s_valid & s_ready;
    assign pop          = m_valid & m_ready;

    // Zero means "open on the first word"; anything above depth saturates at full.
    always_comb begin
        thr = prefill_level;
        if (prefill_level == '0)
            thr = {{AW{1'b0}}, 1'b1};
        else if (prefill_level > DEPTH_C)
            thr = DEPTH_C;
    end

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush)
            mem[wr_ptr[AW-1:0]] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state         <= FILL;
            pre_fill_done <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (count >= thr || (drain && !empty)) begin
                        state         <= RUN;
                        pre_fill_done <= 1'b1;
                    end
                end
                RUN: begin
                    // Holding drain keeps the gate open across an empty FIFO at end of frame.
                    if (!drain && count_next == '0) begin
                        state         <= FILL;
                        pre_fill_done <= 1'b0;
                    end
                end
                default: begin
                    state         <= FILL;
                    pre_fill_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_prefill_mc.sv
// Bench for sync_fifo_prefill_mc: gated (GATE_EN=1) and ungated (GATE_EN=0) copies
// share stimulus and are compared every cycle against a queue-based model.
module tb_sync_fifo_prefill_mc;

    localparam int DW = 8;
    localparam int NC = 4;
    localparam int D  = 16;
    localparam int W  = DW * NC;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          flush;
    logic          drain;
    logic [AW:0]   pl;
    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          m_ready;

    logic          s_ready_o [2];
    logic          m_valid_o [2];
    logic          full_o    [2];
    logic          empty_o   [2];
    logic          af_o      [2];
    logic          ae_o      [2];
    logic          pfd_o     [2];
    logic [W-1:0]  m_data_o  [2];
    logic [AW:0]   count_o   [2];

    sync_fifo_prefill_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .FIFO_DEPTH(D), .GATE_EN(1'b1)) u_gated (
        .clk(clk), .rst(rst), .flush(flush), .drain(drain), .prefill_level(pl),
        .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_data(s_data),
        .m_valid(m_valid_o[0]), .m_ready(m_ready), .m_data(m_data_o[0]),
        .count(count_o[0]), .full(full_o[0]), .empty(empty_o[0]),
        .almost_full(af_o[0]), .almost_empty(ae_o[0]), .pre_fill_done(pfd_o[0])
    );

    sync_fifo_prefill_mc #(.DATA_WIDTH(DW), .NUM_CH(NC), .FIFO_DEPTH(D), .GATE_EN(1'b0)) u_open (
        .clk(clk), .rst(rst), .flush(flush), .drain(drain), .prefill_level(pl),
        .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_data(s_data),
        .m_valid(m_valid_o[1]), .m_ready(m_ready), .m_data(m_data_o[1]),
        .count(count_o[1]), .full(full_o[1]), .empty(empty_o[1]),
        .almost_full(af_o[1]), .almost_empty(ae_o[1]), .pre_fill_done(pfd_o[1])
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] mq [2][$];
    bit           run [2];
    bit           model_ok = 1'b0;

    task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
        end
    endtask

    function automatic int exp_valid(int g);
        return (mq[g].size() > 0 && (g == 1 || run[g])) ? 1 : 0;
    endfunction

    function automatic int threshold();
        int p;
        p = int'(pl);
        if (p == 0)
            return 1;
        return (p > D) ? D : p;
    endfunction

    task automatic compare_all();
        for (int g = 0; g < 2; g++) begin
            int cnt;
            int ev;
            cnt = mq[g].size();
            ev  = exp_valid(g);
            chk("count",        g, 64'(count_o[g]),   64'(cnt));
            chk("s_ready",      g, 64'(s_ready_o[g]), 64'(cnt < D));
            chk("m_valid",      g, 64'(m_valid_o[g]), 64'(ev));
            chk("full",         g, 64'(full_o[g]),    64'(cnt == D));
            chk("empty",        g, 64'(empty_o[g]),   64'(cnt == 0));
            chk("almost_full",  g, 64'(af_o[g]),      64'(cnt >= D - 2));
            chk("almost_empty", g, 64'(ae_o[g]),      64'(cnt <= 2));
            chk("pre_fill_done",g, 64'(pfd_o[g]),     64'(run[g]));
            if (ev != 0)
                chk("m_data",   g, 64'(m_data_o[g]),  64'(mq[g][0]));
        end
    endtask

    // Occupancy, gate and data order derived from the handshake rules, not the RTL encoding.
    task automatic model_update();
        for (int g = 0; g < 2; g++) begin
            int cnt;
            int ev;
            int thr;
            cnt = mq[g].size();
            ev  = exp_valid(g);
            thr = threshold();
            if (rst || flush) begin
                mq[g].delete();
                run[g] = 1'b0;
            end else begin
                if (ev != 0 && m_ready)
                    void'(mq[g].pop_front());
                if (s_valid && cnt < D)
                    mq[g].push_back(s_data);
                if (!run[g])
                    run[g] = (cnt >= thr) || (drain && cnt > 0);
                else if (!drain && mq[g].size() == 0)
                    run[g] = 1'b0;
            end
        end
        if (rst)
            model_ok = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        if (model_ok)
            compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [W-1:0] word(int i);
        return 32'h1020_3040 + W'(i);
    endfunction

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = word(base + i);
            step();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; drain = 1'b0; pl = 5'd8;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_count",   0, 64'(count_o[0]),   64'd0);
        chk("rst_s_ready", 0, 64'(s_ready_o[0]), 64'd1);
        chk("rst_m_valid", 0, 64'(m_valid_o[0]), 64'd0);
        chk("rst_ae",      0, 64'(ae_o[0]),      64'd1);
        chk("rst_pfd",     0, 64'(pfd_o[0]),     64'd0);

        // threshold 8: seven words keep the gate closed, the eighth opens it a cycle later
        m_ready = 1'b1;
        push_words(7, 0);
        step();
        chk("pre7_count",   0, 64'(count_o[0]),   64'd7);
        chk("pre7_m_valid", 0, 64'(m_valid_o[0]), 64'd0);
        push_words(1, 7);
        chk("at8_m_valid",  0, 64'(m_valid_o[0]), 64'd0);
        step();
        chk("open_pfd",     0, 64'(pfd_o[0]),     64'd1);
        chk("open_m_valid", 0, 64'(m_valid_o[0]), 64'd1);
        chk("open_head",    0, 64'(m_data_o[0]),  64'(word(0)));
        repeat (8) step();
        chk("drained_count",0, 64'(count_o[0]),   64'd0);
        chk("drained_pfd",  0, 64'(pfd_o[0]),     64'd0);

        // fill to full with a saturated threshold, then simultaneous push/pop at full
        m_ready = 1'b0;
        pl = 5'd31;
        for (int i = 0; i < D; i++) begin
            s_valid = 1'b1;
            s_data  = $urandom();
            step();
        end
        s_valid = 1'b0;
        chk("full_flag",    0, 64'(full_o[0]),    64'd1);
        chk("full_s_ready", 0, 64'(s_ready_o[0]), 64'd0);
        chk("full_gate",    0, 64'(m_valid_o[0]), 64'd0);
        step();
        chk("full_open",    0, 64'(m_valid_o[0]), 64'd1);
        s_valid = 1'b1; m_ready = 1'b1; s_data = $urandom();
        step();
        chk("full_pop_only",0, 64'(count_o[0]),   64'd15);
        s_data = $urandom();
        step();
        chk("both_count",   0, 64'(count_o[0]),   64'd15);
        s_valid = 1'b0;
        repeat (D) step();

        // lane placement and a randomized run across pointer wraparound
        pl = 5'd1; m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'hDDCC_BBAA;
        step();
        s_valid = 1'b0;
        step();
        chk("lane1", 0, 64'(m_data_o[0][15:8]), 64'h0000_00BB);
        pl = 5'd4;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data  = $urandom();
            step();
        end
        s_valid = 1'b0; m_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;

        // fall back to FILL on empty, then drain forces the gate open
        pl = 5'd3;
        push_words(3, 100);
        step();
        pl = 5'd8; m_ready = 1'b1;
        repeat (3) step();
        chk("refill_pfd",   0, 64'(pfd_o[0]),     64'd0);
        m_ready = 1'b0;
        push_words(3, 200);
        step();
        chk("refill_gate",  0, 64'(m_valid_o[0]), 64'd0);
        drain = 1'b1;
        step();
        chk("drain_open",   0, 64'(m_valid_o[0]), 64'd1);
        m_ready = 1'b1;
        repeat (3) step();
        chk("drain_count",  0, 64'(count_o[0]),   64'd0);
        chk("drain_hold",   0, 64'(pfd_o[0]),     64'd1);
        drain = 1'b0;
        step();
        chk("drain_release",0, 64'(pfd_o[0]),     64'd0);

        // flush with a concurrent write loses everything
        pl = 5'd16; m_ready = 1'b0;
        push_words(10, 300);
        chk("preflush_cnt", 0, 64'(count_o[0]),   64'd10);
        flush = 1'b1; s_valid = 1'b1; s_data = word(400);
        step();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush_count",  0, 64'(count_o[0]),   64'd0);
        chk("flush_empty",  0, 64'(empty_o[0]),   64'd1);
        chk("flush_pfd",    0, 64'(pfd_o[0]),     64'd0);

        // zero threshold opens after one word; the ungated copy shows data immediately
        pl = 5'd0;
        push_words(1, 500);
        chk("ungated_valid",1, 64'(m_valid_o[1]), 64'd1);
        chk("gated_wait",   0, 64'(m_valid_o[0]), 64'd0);
        step();
        chk("thr0_open",    0, 64'(m_valid_o[0]), 64'd1);
        chk("thr0_head",    0, 64'(m_data_o[0]),  64'(word(500)));

        // long random mix, including resets, flushes, drain and threshold changes
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) == 0);
            flush   = ($urandom_range(0, 49) == 0);
            drain   = ($urandom_range(0, 9) == 0);
            s_valid = ($urandom_range(0, 9) < 6);
            m_ready = ($urandom_range(0, 9) < 5);
            s_data  = $urandom();
            if ($urandom_range(0, 15) == 0)
                pl = 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; flush = 1'b0; drain = 1'b0; s_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
